subservient_ram_arb: RTL
========================

// Module: subservient_ram_arb
// PURPOSE
// Shared register-file / memory SRAM port for the subservient SoC, generalised over SRAM data width and
// Wishbone channel count. The serial RF has absolute priority. NCH 32-bit Wishbone slaves (e.g. ibus, dbus)
// are round-robin arbitrated and serialised into 32/DW SRAM beats with byte masks. x0 reads return zero.
// PARAMETERS
// DEPTH  256  SRAM depth in DW-bit words (power of two)
// DW     8    SRAM data width: 8, 16 or 32
// NCH    2    number of Wishbone channels, 1..4
// AW     $clog2(DEPTH)  SRAM address width (derived, do not override)
// BEATS  32/DW; BW = $clog2(BEATS), with BW=0 when DW=32 (derived)
// PORTS
// i_clk         in   1           clock, all logic on rising edge
// i_rst_n       in   1           asynchronous active-low reset
// i_waddr       in   AW          RF write address
// i_wdata       in   DW          RF write data
// i_wen         in   1           RF write enable
// i_raddr       in   AW          RF read address
// i_ren         in   1           RF read enable
// o_rdata       out  DW          RF read data, 1-cycle latency, zeroed for x0
// o_sram_waddr  out  AW          SRAM write address
// o_sram_wdata  out  DW          SRAM write data
// o_sram_wmask  out  DW/8        SRAM byte write mask, all ones for RF writes
// o_sram_wen    out  1           SRAM write enable
// o_sram_raddr  out  AW          SRAM read address
// i_sram_rdata  in   DW          SRAM read data, valid the cycle after o_sram_ren
// o_sram_ren    out  1           SRAM read enable
// i_wb_adr      in   NCH*(AW-BW) per-channel word address, channel c at [c*(AW-BW)+:AW-BW]
// i_wb_dat      in   NCH*32      per-channel write data
// i_wb_sel      in   NCH*4       per-channel byte selects
// i_wb_we       in   NCH         per-channel write strobe
// i_wb_stb      in   NCH         per-channel request
// o_wb_rdt      out  32          read data, shared, valid only with an ack
// o_wb_ack      out  NCH         per-channel one-cycle acknowledge
// BEHAVIOUR
// - Reset: state=IDLE, beat count cnt=0, rr pointer=0, o_wb_ack=0, captured rdata=0, regzero=0.
//   Mid-transaction reset aborts the transaction silently. No ack is issued.
// - FSM IDLE -> BUSY: any stb set. Grant = first requesting channel at or after rr, cyclic.
//   rr <= grant+1 mod NCH. Grant is latched until ACK.
// - BUSY: a beat issues when i_wen=0 and i_ren=0; otherwise the SRAM muxes pass the RF through and cnt holds.
//   Beat: addr={adr[g],cnt}; wdata=dat[g][cnt*DW+:DW]; wmask=sel[g][cnt*DW/8+:DW/8]; wen=we[g]&|wmask; ren=!we[g].
//   cnt increments per issued beat. Issuing beat BEATS-1 -> ACK, cnt wraps to 0.
// - ACK (one cycle): o_wb_ack[g]=1, no beat, RF passes through. Next state is IDLE; re-arbitration
//   happens one cycle later, so a master holding stb in the ack cycle is not re-served.
// - Read data: a flag registers each issued read beat. The cycle after flagged beat k<BEATS-1, store i_sram_rdata
//   into slot k. o_wb_rdt = {i_sram_rdata, slots[BEATS-2:0]}; the last beat lands exactly in the ACK cycle.
//   Stalls between beats do not corrupt the captured slots.
// - Write-only transaction with sel=0: beats still run, wen stays 0, ack is still issued.
//   A stb dropped mid-transaction is a protocol error; the transaction completes and acks regardless.
// - regzero <= &i_raddr[AW-1:BW] every cycle. o_rdata = regzero ? 0 : i_sram_rdata.
// - Latency with an idle RF: BEATS+1 cycles from grant to ack. Outputs to the SRAM are combinational muxes.
// TESTING
// 1 DW=8,NCH=1: write adr=5,dat=32'hA1B2C3D4,sel=4'hF -> SRAM bytes 20..23=D4,C3,B2,A1; ack at cycle 5.
// 2 Read back adr=5 -> o_wb_rdt=32'hA1B2C3D4 with ack; then sel=4'b0100 write of 32'h00EE0000 -> only byte 22 = EE.
// 3 NCH=2: both stb together, back to back -> ack order ch0,ch1,ch0,ch1. No channel is served twice in a row while the other waits.
// 4 i_wen toggles every other cycle during a DW=8 read -> SRAM never sees WB+RF in one cycle; rdt still correct; ack delayed by stalls.
// 5 DW=16 and DW=32 writes with sel=4'b0011 -> wmask 2'b11 then 2'b00 (DW=16); 4'b0011 (DW=32); ack after 3 and 2 cycles.
// 6 RF read of i_raddr=DEPTH-1 -> o_rdata=0 next cycle; i_rst_n low in mid-transaction -> no ack, cnt=0, next request starts at beat 0.

Source files
------------

// File: rtl/subservient_ram_arb.sv
// Shared SRAM port: serial RF has absolute priority, NCH Wishbone slaves are round-robin
// arbitrated and split into 32/DW SRAM beats with byte masks.
//
// state | meaning
// IDLE  | no transaction; arbitrate among requesting channels
// BUSY  | issuing beats for the granted channel whenever the RF leaves the SRAM free
// ACK   | one-cycle acknowledge to the granted channel; last read beat lands here
module subservient_ram_arb #(
  parameter int DEPTH = 256,
  parameter int DW = 8,
  parameter int NCH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int BEATS = 32 / DW,
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [AW-1:0]           i_waddr,
  input  logic [DW-1:0]           i_wdata,
  input  logic                    i_wen,
  input  logic [AW-1:0]           i_raddr,
  input  logic                    i_ren,
  output logic [DW-1:0]           o_rdata,
  output logic [AW-1:0]           o_sram_waddr,
  output logic [DW-1:0]           o_sram_wdata,
  output logic [DW/8-1:0]         o_sram_wmask,
  output logic                    o_sram_wen,
  output logic [AW-1:0]           o_sram_raddr,
  input  logic [DW-1:0]           i_sram_rdata,
  output logic                    o_sram_ren,
  input  logic [NCH*(AW-BW)-1:0]  i_wb_adr,
  input  logic [NCH*32-1:0]       i_wb_dat,
  input  logic [NCH*4-1:0]        i_wb_sel,
  input  logic [NCH-1:0]          i_wb_we,
  input  logic [NCH-1:0]          i_wb_stb,
  output logic [31:0]             o_wb_rdt,
  output logic [NCH-1:0]          o_wb_ack
);

  localparam int CW = (BW > 0) ? BW : 1;
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MW = DW / 8;
  localparam int XW = AW - BW;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grant_q, grant_nxt, rr, arb_sel;
  logic          arb_found;
  logic [CW-1:0] cnt;
  logic          issue, last_beat, regzero;

  logic [XW-1:0] adr_g;
  logic [31:0]   dat_g;
  logic [3:0]    sel_g;
  logic          we_g;
  logic [AW-1:0] beat_addr;
  logic [DW-1:0] beat_wdata;
  logic [MW-1:0] beat_wmask;

  assign adr_g = i_wb_adr[grant_q*XW +: XW];
  assign dat_g = i_wb_dat[grant_q*32 +: 32];
  assign sel_g = i_wb_sel[grant_q*4 +: 4];
  assign we_g  = i_wb_we[grant_q];

  assign beat_wdata = dat_g[cnt*DW +: DW];
  assign beat_wmask = sel_g[cnt*MW +: MW];

  generate
    if (BW == 0) begin : g_addr_word
      assign beat_addr = adr_g;
    end else begin : g_addr_beat
      assign beat_addr = {adr_g, cnt};
    end
  endgenerate

  assign issue     = (state == BUSY) && !i_wen && !i_ren;
  assign last_beat = (cnt == CW'(BEATS - 1));

  // Cyclic search starting at the round-robin pointer
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!arb_found && i_wb_stb[(int'(rr) + i) % NCH]) begin
        arb_found = 1'b1;
        arb_sel   = GW'((int'(rr) + i) % NCH);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    o_wb_ack  = '0;
    case (state)
      IDLE: if (arb_found) begin
        state_nxt = BUSY;
        grant_nxt = arb_sel;
      end
      BUSY: if (issue && last_beat) state_nxt = ACK;
      ACK: begin
        o_wb_ack[grant_q] = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_sram_waddr = i_waddr;
    o_sram_wdata = i_wdata;
    o_sram_wmask = '1;
    o_sram_wen   = i_wen;
    o_sram_raddr = i_raddr;
    o_sram_ren   = i_ren;
    if (issue) begin
      o_sram_waddr = beat_addr;
      o_sram_wdata = beat_wdata;
      o_sram_wmask = beat_wmask;
      o_sram_wen   = we_g & (|beat_wmask);
      o_sram_raddr = beat_addr;
      o_sram_ren   = !we_g;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      rr      <= '0;
      cnt     <= '0;
      regzero <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      regzero <= &i_raddr[AW-1:BW];
      if (state == IDLE && arb_found)
        rr <= (arb_sel == GW'(NCH - 1)) ? '0 : arb_sel + GW'(1);
      if (issue)
        cnt <= last_beat ? '0 : cnt + CW'(1);
    end
  end

  assign o_rdata = regzero ? '0 : i_sram_rdata;

  // The final beat is never stored: it is forwarded straight from the SRAM in the ACK cycle
  generate
    if (BW > 0) begin : g_slots
      logic              rd_flag;
      logic [CW-1:0]     rd_idx;
      logic [32-DW-1:0]  slots;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          rd_flag <= 1'b0;
          rd_idx  <= '0;
          slots   <= '0;
        end else begin
          rd_flag <= issue & ~we_g;
          rd_idx  <= cnt;
          if (rd_flag && rd_idx != CW'(BEATS - 1))
            slots[rd_idx*DW +: DW] <= i_sram_rdata;
        end
      end
      assign o_wb_rdt = {i_sram_rdata, slots};
    end else begin : g_noslots
      assign o_wb_rdt = i_sram_rdata;
    end
  endgenerate

endmodule
